// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//
// Performs a wide unsigned add by reusing one external combinational 4-bit
// adder slice over NIBBLES nibbles, least-significant nibble first. The
// slice carry-out of one nibble becomes the carry-in of the next.
//
// Optional feature macro: ADDER_SEQ_OVF_EN adds the signed-overflow output
// `ovf`. When the macro is undefined, the port and its register are absent.
//
// Ports
//   clk, rst          system clock; asynchronous active-high reset
//   start, a, b, c_in request and operands; sampled only in IDLE
//   busy              high while nibbles are being processed (RUN)
//   done              one-cycle pulse when sum/c_out become valid
//   sum, c_out        result and final carry; held until the next accepted start
//   slice_a/b/cin     drive to the shared adder slice (zero outside RUN)
//   slice_sum/cout    combinational return from the shared adder slice
//   ovf               signed overflow (ADDER_SEQ_OVF_EN only)
//
// State table
//   IDLE | waiting for start; result registers hold the last result
//   RUN  | one nibble per cycle through the slice, idx_q selects the nibble
//   DONE | result valid, done pulse; returns to IDLE unconditionally

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   c_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   c_out,
  output logic [3:0]             slice_a,
  output logic [3:0]             slice_b,
  output logic                   slice_cin,
  input  logic [3:0]             slice_sum,
  input  logic                   slice_cout
`ifdef ADDER_SEQ_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             busy_q;
  logic             done_q;
`ifdef ADDER_SEQ_OVF_EN
  logic             ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= c_in;
            idx_q   <= '0;
            sum_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef ADDER_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        RUN: begin
          sum_q[idx_q*4 +: 4] <= slice_sum;
          carry_q             <= slice_cout;
          idx_q               <= idx_q + IDX_ONE;
          if (idx_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef ADDER_SEQ_OVF_EN
            // slice_sum[3] is the result MSB while the top nibble is on the slice
            ovf_q   <= (a_q[W-1] == b_q[W-1]) && (slice_sum[3] != a_q[W-1]);
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Slice is only driven while a nibble is in flight so it sees quiet inputs otherwise.
  always_comb begin
    slice_a   = 4'd0;
    slice_b   = 4'd0;
    slice_cin = 1'b0;
    if (state_q == RUN) begin
      slice_a   = a_q[idx_q*4 +: 4];
      slice_b   = b_q[idx_q*4 +: 4];
      slice_cin = carry_q;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = carry_q;
`ifdef ADDER_SEQ_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl (NIBBLES=4). A behavioural 4-bit slice
// closes the loop; expected results are queued when a start is driven and
// compared when done pulses.

module tb_nibble_serial_adder_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic [3:0]   slice_a;
  logic [3:0]   slice_b;
  logic         slice_cin;
  logic [3:0]   slice_sum;
  logic         slice_cout;
`ifdef ADDER_SEQ_OVF_EN
  logic         ovf;
`endif

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .c_in       (c_in),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .c_out      (c_out),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_sum  (slice_sum),
    .slice_cout (slice_cout)
`ifdef ADDER_SEQ_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  // External 4-bit adder slice
  logic [4:0] slice_res;
  assign slice_res  = {1'b0, slice_a} + {1'b0, slice_b} + {4'd0, slice_cin};
  assign slice_sum  = slice_res[3:0];
  assign slice_cout = slice_res[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   done_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin);
    exp_t       e;
    logic [W:0] r;
    r      = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tcin};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (ta[W-1] == tb_v[W-1]) && (r[W-1] != ta[W-1]);
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sum", 32'(sum), 32'(e.sum));
          chk("c_out", 32'(c_out), 32'(e.cout));
          chk("busy_in_done", 32'(busy), 32'd0);
`ifdef ADDER_SEQ_OVF_EN
          chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
        end
      end
    end
  endtask

  // Drives one request, scrambles operands after acceptance, and measures
  // latency, busy length and the per-RUN-cycle slice carry-in.
  task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                        input exp_t e, output logic [15:0] cin_trace);
    int cyc;
    int busy_cnt;
    bit seen;
    cin_trace = '0;
    @(negedge clk);
    a = ta; b = tb_v; c_in = tcin; start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
    cyc = 0; busy_cnt = 0; seen = 0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) begin
        if (busy_cnt < 16) cin_trace[busy_cnt] = slice_cin;
        busy_cnt++;
      end
      if (done === 1'b1) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(cyc), 32'(NIBBLES + 1));
    chk("busy_cycles", 32'(busy_cnt), 32'(NIBBLES));
  endtask

  vec_t        vecs[8];
  logic [15:0] trace;
  exp_t        e;

  initial begin
    checks = 0; errors = 0; done_cnt = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[7] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
`ifdef ADDER_SEQ_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      e.sum = vecs[i].exp_sum; e.cout = vecs[i].exp_cout; e.ovf = vecs[i].exp_ovf;
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, e, trace);
      if (i == 1) chk("ripple_slice_cin", 32'(trace[3:0]), 32'h0000000E);
    end

    // Result holds after done
    repeat (3) @(negedge clk);
    chk("sum_hold", 32'(sum), 32'h00000100);
    chk("c_out_hold", 32'(c_out), 32'd0);

    // Random vectors against the wide-add model
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      do_add(ra, rb, rc, model(ra, rb, rc), trace);
    end

    // start during RUN is ignored
    begin
      int d0, bc;
      d0 = done_cnt; bc = 0;
      @(negedge clk);
      a = 16'h0001; b = 16'h0001; c_in = 1'b0; start = 1'b1;
      sb.push_back(model(16'h0001, 16'h0001, 1'b0));
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 14; k++) begin
        @(negedge clk);
        if (k == 2) begin start = 1'b1; a = 16'h1111; b = 16'h2222; end
        if (k == 3) start = 1'b0;
        if (busy === 1'b1) bc++;
      end
      chk("ignored_start_dones", 32'(done_cnt - d0), 32'd1);
      chk("ignored_start_busy", 32'(bc), 32'(NIBBLES));
    end

    // Reset during RUN cycle 2 aborts the operation
    begin
      int d0;
      @(negedge clk);
      a = 16'h1119; b = 16'h1118; c_in = 1'b0; start = 1'b1;
      sb.push_back(model(16'h1119, 16'h1118, 1'b0));
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_sum", 32'(sum), 32'h00000001);
      rst = 1'b1;
      sb.delete();
      d0 = done_cnt;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_c_out", 32'(c_out), 32'd0);
      chk("abort_slice_a", 32'(slice_a), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      e = model(16'h00FF, 16'h0001, 1'b0);
      do_add(16'h00FF, 16'h0001, 1'b0, e, trace);
    end

    // start held high: back-to-back at one add per NIBBLES+2 cycles
    begin
      int d0;
      int first_done;
      int last_done;
      d0 = done_cnt; first_done = -1; last_done = -1;
      @(negedge clk);
      a = 16'hABCD; b = 16'h1234; c_in = 1'b1; start = 1'b1;
      repeat (3) sb.push_back(model(16'hABCD, 16'h1234, 1'b1));
      for (int k = 1; k <= 22; k++) begin
        @(negedge clk);
        if (k == 13) start = 1'b0;
        if (done === 1'b1) begin
          if (first_done < 0) first_done = k;
          last_done = k;
        end
      end
      chk("b2b_dones", 32'(done_cnt - d0), 32'd3);
      chk("b2b_first_done", 32'(first_done), 32'(NIBBLES + 1));
      chk("b2b_spacing", 32'(last_done - first_done), 32'(2 * (NIBBLES + 2)));
    end

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that performs a wide binary add by time-multiplexing one external combinational 4-bit adder slice (`adder_4bit`) across `NIBBLES` nibbles, least-significant first. The slice's `c_out` is carried into the next nibble's `c_in`. It sits between a requester issuing `start`/operands and the shared 4-bit adder instance, trading throughput for area on wide additions.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; operand width W = 4*NIBBLES; legal range 2..16.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  W  operand A, sampled with `start`.
- `b`  input  W  operand B, sampled with `start`.
- `c_in`  input  1  carry-in, sampled with `start`.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse: result valid.
- `sum`  output  W  result; holds until the next accepted `start`.
- `c_out`  output  1  final carry; holds like `sum`.
- `slice_a`  output  4  to adder slice `a`.
- `slice_b`  output  4  to adder slice `b`.
- `slice_cin`  output  1  to adder slice `c_in`.
- `slice_sum`  input  4  from adder slice `sum` (combinational).
- `slice_cout`  input  1  from adder slice `c_out` (combinational).
- `ovf`  output  1  signed overflow; present only with `ADDER_SEQ_OVF_EN`.

## Operation
- Registers: `a_q`, `b_q` (W), `carry_q` (1), `idx_q` (clog2(NIBBLES)), `sum_q` (W), `state_q`.
- FSM states: IDLE -> RUN on `start`; RUN -> RUN while `idx_q` < NIBBLES-1; RUN -> DONE at the edge where `idx_q` == NIBBLES-1; DONE -> IDLE unconditionally.
- IDLE with `start`=1: `a_q`<=`a`, `b_q`<=`b`, `carry_q`<=`c_in`, `idx_q`<=0, `sum_q`<=0.
- RUN, each edge: `sum_q[4*idx_q +: 4]`<=`slice_sum`, `carry_q`<=`slice_cout`, `idx_q`<=`idx_q`+1.
- Slice drive: in RUN, `slice_a`=`a_q[4*idx_q +: 4]`, `slice_b`=`b_q[4*idx_q +: 4]`, `slice_cin`=`carry_q`; otherwise all three are 0.
- `sum`=`sum_q`; `c_out`=`carry_q`, and is held from DONE onward until the next accepted `start`.
- `start` in RUN or DONE is ignored and is not queued; operand changes after acceptance do not affect the result.
- Arithmetic is unsigned modulo 2^W; the carry beyond bit W-1 appears only on `c_out`.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `sum`=0, `c_out`=0, slice outputs 0, `ovf`=0.
- `start` accepted at edge E0. `busy`=1 after E0 through edge E0+NIBBLES.
- `done`=1 for exactly the cycle after edge E0+NIBBLES; `busy`=0 in that cycle.
- Latency from `start` to `done` is NIBBLES+1 cycles. The earliest next accepted `start` is at edge E0+NIBBLES+2, so throughput is one add per NIBBLES+2 cycles.
- Slice path: combinational, and must settle within one `clk` period (`slice_a`/`slice_b`/`slice_cin` -> `slice_sum`/`slice_cout`).
- `rst` asserted mid-operation: immediate return to IDLE with reset values. No `done` is produced, and the aborted result is discarded.
- `start` held high continuously: a new operation is accepted on every IDLE cycle, i.e. back-to-back at maximum throughput.

## Configuration
- `ADDER_SEQ_OVF_EN` defined: adds the `ovf` port and register. At the RUN->DONE edge, `ovf`<=(`a_q[W-1]`==`b_q[W-1]`) && (`slice_sum[3]`!=`a_q[W-1]`). `ovf` holds like `sum`, and is cleared at reset and at each accepted `start`.
- `ADDER_SEQ_OVF_EN` undefined: the `ovf` port and logic are absent. All other behaviour is identical.

## Test plan
- NIBBLES=4: `a`=0x1234, `b`=0x4321, `c_in`=0 -> `sum`=0x5555, `c_out`=0. `done` is high 5 cycles after the `start` edge, and `busy` is high for 4 cycles.
- `a`=0xFFFF, `b`=0x0001, `c_in`=0 -> `sum`=0x0000, `c_out`=1. This checks carry ripple across all nibbles; `slice_cin`=1 in RUN cycles 2-4.
- `a`=0xFFFF, `b`=0x0000, `c_in`=1 -> `sum`=0x0000, `c_out`=1. Then `a`=0x0000, `b`=0x0000, `c_in`=0 -> `sum`=0x0000, `c_out`=0.
- Pulse `start` with `a`=0x1111, `b`=0x2222 during RUN of 0x0001+0x0001 -> result is 0x0002. The second request is ignored, and only one `done` pulse occurs.
- Assert `rst` during RUN cycle 2 -> `busy`=0, `sum`=0, `c_out`=0, with no `done`. A new start with 0x00FF+0x0001 -> 0x0100.
- With `ADDER_SEQ_OVF_EN`: 0x7FFF+0x0001 -> `sum`=0x8000, `ovf`=1. 0x8000+0xFFFF -> `sum`=0x7FFF, `ovf`=1, `c_out`=1. 0x0001+0x0001 -> `ovf`=0.
